inv_clark_transform: RTL and testbench

Serial, handshaked inverse Clarke transform: converts one alpha/beta/gamma sample (signed Q15) back into three phase quantities a/b/c using a single shared multiplier and a small state machine. It sits downstream of the current/voltage controllers and upstream of the SVPWM duty-cycle stage. It is the return path of `clark_transform`, using amplitude-invariant scaling so that a forward-then-inverse round trip is unity gain.

---
 rtl/inv_clark_transform.sv | 123 ++++++++++++
 tb/tb_inv_clark_transform.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/inv_clark_transform.sv
// Serial inverse Clarke transform: alpha/beta/gamma (Q15) to phases a/b/c, sharing one
// multiplier across a four-state IDLE/MULT/SUM/OUT sequence with valid/ready handshakes.
module inv_clark_transform #(
   parameter int K_SQRT3_2 = 28378
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] alpha,
   input  logic [15:0] beta,
   input  logic [15:0] gamma,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [15:0] a,
   output logic [15:0] b,
   output logic [15:0] c,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        sat
);

   localparam logic signed [31:0] KCoef = 32'(K_SQRT3_2);

   typedef enum logic [1:0] {StIdle, StMult, StSum, StOut} state_e;

   state_e             state_q, state_d;
   logic signed [15:0] alpha_q, beta_q, gamma_q;
   logic signed [31:0] prod_q, prod_d;
   logic signed [15:0] a_q, b_q, c_q;
   logic signed [15:0] a_d, b_d, c_d;
   logic               sat_q, sat_d;
   logic               out_valid_q;

   logic signed [17:0] alpha_x, gamma_x, half_x, rnd_x;
   logic signed [17:0] sum_a, sum_b, sum_c;
   logic signed [31:0] beta_x;

   function automatic logic signed [15:0] clip16(input logic signed [17:0] s);
      if (s > 18'sd32767) begin
         return 16'sh7fff;
      end else if (s < -18'sd32768) begin
         return 16'sh8000;
      end else begin
         return s[15:0];
      end
   endfunction

   // Value fits 16 bits exactly when the top three bits agree.
   function automatic logic ovf(input logic signed [17:0] s);
      return (s[17:15] != 3'b000) && (s[17:15] != 3'b111);
   endfunction

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (in_valid) state_d = StMult;
         StMult:  state_d = StSum;
         StSum:   state_d = StOut;
         StOut:   if (out_ready) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      beta_x  = {{16{beta_q[15]}}, beta_q};
      prod_d  = beta_x * KCoef;
      alpha_x = {{2{alpha_q[15]}}, alpha_q};
      gamma_x = {{2{gamma_q[15]}}, gamma_q};
      half_x  = alpha_x >>> 1;
      // Round-half-up of the Q30 product back to Q15.
      rnd_x   = 18'((prod_q + 32'sd16384) >>> 15);
      sum_a   = alpha_x + gamma_x;
      sum_b   = gamma_x - half_x + rnd_x;
      sum_c   = gamma_x - half_x - rnd_x;
      a_d     = clip16(sum_a);
      b_d     = clip16(sum_b);
      c_d     = clip16(sum_c);
      sat_d   = ovf(sum_a) | ovf(sum_b) | ovf(sum_c);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         alpha_q     <= '0;
         beta_q      <= '0;
         gamma_q     <= '0;
         prod_q      <= '0;
         a_q         <= '0;
         b_q         <= '0;
         c_q         <= '0;
         sat_q       <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         unique case (state_q)
            StIdle: begin
               if (in_valid) begin
                  alpha_q <= alpha;
                  beta_q  <= beta;
                  gamma_q <= gamma;
               end
            end
            StMult: prod_q <= prod_d;
            StSum: begin
               a_q         <= a_d;
               b_q         <= b_d;
               c_q         <= c_d;
               sat_q       <= sat_d;
               out_valid_q <= 1'b1;
            end
            StOut:   if (out_ready) out_valid_q <= 1'b0;
            default: out_valid_q <= 1'b0;
         endcase
      end
   end

   assign in_ready  = (state_q == StIdle) && rst_n;
   assign a         = a_q;
   assign b         = b_q;
   assign c         = c_q;
   assign sat       = sat_q;
   assign out_valid = out_valid_q;

endmodule

// File: tb/tb_inv_clark_transform.sv
// Directed plus random-stream bench for inv_clark_transform with a queue scoreboard.
module tb_inv_clark_transform;

   localparam int K = 28378;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] alpha = '0, beta = '0, gamma = '0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] a, b, c;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic        sat;

   typedef struct {int a; int b; int c; int s;} exp_t;
   exp_t q[$];

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   inv_clark_transform #(.K_SQRT3_2(K)) dut (
      .clk(clk), .rst_n(rst_n), .alpha(alpha), .beta(beta), .gamma(gamma),
      .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .c(c),
      .out_valid(out_valid), .out_ready(out_ready), .sat(sat)
   );

   function automatic int clip(input int v);
      if (v > 32767) return 32767;
      if (v < -32768) return -32768;
      return v;
   endfunction

   function automatic exp_t model(input int al, input int be, input int ga);
      exp_t   e;
      longint p;
      int     r, half, sa, sb, sc;
      p    = longint'(be) * longint'(K);
      r    = int'((p + 64'sd16384) >>> 15);
      half = al >>> 1;
      sa   = al + ga;
      sb   = -half + r + ga;
      sc   = -half - r + ga;
      e.a  = clip(sa);
      e.b  = clip(sb);
      e.c  = clip(sc);
      e.s  = ((sa != e.a) || (sb != e.b) || (sc != e.c)) ? 1 : 0;
      return e;
   endfunction

   task automatic chk(input string tag, input int obs, input int exp_v);
      n_checks++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
      end
   endtask

   task automatic chk_result(input string tag);
      exp_t e;
      if (q.size() == 0) begin
         chk({tag, "_queue_nonempty"}, 0, 1);
      end else begin
         e = q.pop_front();
         chk({tag, "_a"}, int'($signed(a)), e.a);
         chk({tag, "_b"}, int'($signed(b)), e.b);
         chk({tag, "_c"}, int'($signed(c)), e.c);
         chk({tag, "_sat"}, int'(sat), e.s);
      end
   endtask

   task automatic drive(input int al, input int be, input int ga);
      alpha = 16'(al);
      beta  = 16'(be);
      gamma = 16'(ga);
   endtask

   // Accept one sample, check fixed latency and result, consume it.
   task automatic run_one(input string tag, input int al, input int be, input int ga);
      chk({tag, "_in_ready"}, int'(in_ready), 1);
      drive(al, be, ga);
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      q.push_back(model(al, be, ga));
      chk({tag, "_ov_mult"}, int'(out_valid), 0);
      @(posedge clk); #1;
      chk({tag, "_ov_sum"}, int'(out_valid), 0);
      @(posedge clk); #1;
      chk({tag, "_ov_out"}, int'(out_valid), 1);
      chk_result(tag);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk({tag, "_ov_clr"}, int'(out_valid), 0);
      chk({tag, "_rdy_back"}, int'(in_ready), 1);
   endtask

   initial begin
      exp_t hold;
      int   al, be, ga, n_acc, cyc, last;
      logic take;

      #1;
      chk("rst_in_ready", int'(in_ready), 0);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_a", int'($signed(a)), 0);
      chk("rst_sat", int'(sat), 0);
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      run_one("full_alpha", 32767, 0, 0);
      run_one("pos_beta", 0, 32767, 0);
      run_one("neg_beta", 0, -32768, 0);
      run_one("clip_pos", 32767, 0, 32767);
      run_one("clip_neg", -32768, 0, -32768);
      run_one("mixed", -12345, 23456, 1000);

      // Backpressure: result held, second sample waits.
      drive(1000, -2000, 300);
      in_valid = 1'b1;
      @(posedge clk); #1;
      q.push_back(model(1000, -2000, 300));
      drive(-7000, 9000, -500);
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("bp_ov", int'(out_valid), 1);
      hold = q[0];
      for (int i = 0; i < 10; i++) begin
         chk("bp_a", int'($signed(a)), hold.a);
         chk("bp_b", int'($signed(b)), hold.b);
         chk("bp_c", int'($signed(c)), hold.c);
         chk("bp_sat", int'(sat), hold.s);
         chk("bp_in_ready", int'(in_ready), 0);
         @(posedge clk); #1;
      end
      chk_result("bp_first");
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("bp_rdy_after", int'(in_ready), 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      q.push_back(model(-7000, 9000, -500));
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("bp_second_ov", int'(out_valid), 1);
      chk_result("bp_second");
      out_ready = 1'b1;
      @(posedge clk); #1;

      // Random stream with both handshakes tied high.
      al = int'($urandom_range(0, 65535)) - 32768;
      be = int'($urandom_range(0, 65535)) - 32768;
      ga = int'($urandom_range(0, 65535)) - 32768;
      drive(al, be, ga);
      in_valid = 1'b1;
      n_acc = 0;
      cyc = 0;
      last = -1;
      while ((n_acc < 1000 || q.size() > 0) && cyc < 6000) begin
         @(negedge clk);
         if (out_valid) begin
            chk_result("stream");
            if (last >= 0) chk("stream_interval", cyc - last, 4);
            last = cyc;
         end
         take = in_valid && in_ready;
         @(posedge clk); #1;
         cyc++;
         if (take) begin
            q.push_back(model(al, be, ga));
            n_acc++;
            if (n_acc < 1000) begin
               al = int'($urandom_range(0, 65535)) - 32768;
               be = int'($urandom_range(0, 65535)) - 32768;
               ga = int'($urandom_range(0, 65535)) - 32768;
               drive(al, be, ga);
            end else begin
               in_valid = 1'b0;
            end
         end
      end
      chk("stream_accepted", n_acc, 1000);
      chk("stream_drained", q.size(), 0);
      out_ready = 1'b0;
      @(posedge clk); #1;

      // Reset while in SUM discards the in-flight sample.
      drive(20000, 20000, 20000);
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_ov", int'(out_valid), 0);
      chk("mid_rst_a", int'($signed(a)), 0);
      chk("mid_rst_b", int'($signed(b)), 0);
      chk("mid_rst_c", int'($signed(c)), 0);
      chk("mid_rst_in_ready", int'(in_ready), 0);
      @(posedge clk); #1;
      chk("mid_rst_ov_held", int'(out_valid), 0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("post_rst_ov", int'(out_valid), 0);
      run_one("post_rst", 5000, -3000, 100);
      chk("post_rst_queue", q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
